dmem_access_ctrl: RTL

//  Load/store sequencer directly upstream of the 512x8 byte-addressed data RAM (ram512x8).

---
 rtl/dmem_access_ctrl_if.sv | 37 +++
 rtl/dmem_access_ctrl.sv | 111 +++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl_if.sv
// Request/response and RAM-side signal bundle for dmem_access_ctrl.
// master = MEM stage plus RAM environment, slave = the controller.
interface dmem_access_ctrl_if #(
  parameter int MEM_ADDR_W = 9,
  parameter int XLEN       = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_rw;
  logic [1:0]            req_size;
  logic                  req_sign;
  logic [XLEN-1:0]       req_addr;
  logic [XLEN-1:0]       req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [XLEN-1:0]       rsp_rdata;
  logic                  rsp_err;
  logic                  mem_enable;
  logic                  mem_rw;
  logic [1:0]            mem_size;
  logic                  mem_se;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]       mem_wdata;
  logic [XLEN-1:0]       mem_rdata;

  modport master (
    output req_valid, req_rw, req_size, req_sign, req_addr, req_wdata, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_enable, mem_rw, mem_size, mem_se, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_rw, req_size, req_sign, req_addr, req_wdata, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_enable, mem_rw, mem_size, mem_se, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer in front of the byte-addressed data RAM (setup/strobe/capture).
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned half/word accesses.
module dmem_access_ctrl #(
  parameter int MEM_ADDR_W = 9,
  parameter int XLEN       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, CAPTURE, RESP} state_t;

  state_t                state;
  logic [1:0]            bytes_m1;
  logic [MEM_ADDR_W:0]   end_addr;
  logic                  size_ok;
  logic                  hi_ok;
  logic                  range_ok;
  logic                  align_ok;
  logic                  req_ok;

  always_comb begin
    bytes_m1 = 2'd0;
    case (bus.req_size)
      2'b01:   bytes_m1 = 2'd1;
      2'b10:   bytes_m1 = 2'd3;
      default: bytes_m1 = 2'd0;
    endcase
  end

  // One extra bit so an access running past the top of RAM is caught, not wrapped.
  assign end_addr = {1'b0, bus.req_addr[MEM_ADDR_W-1:0]} + {{(MEM_ADDR_W-1){1'b0}}, bytes_m1};
  assign size_ok  = (bus.req_size != 2'b11);
  assign hi_ok    = (bus.req_addr[XLEN-1:MEM_ADDR_W] == '0);
  assign range_ok = ~end_addr[MEM_ADDR_W];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign align_ok = !(((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                      ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00)));
`else
  assign align_ok = 1'b1;
`endif

  assign req_ok = size_ok && hi_ok && range_ok && align_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.req_ready  <= 1'b1;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_err    <= 1'b0;
      bus.rsp_rdata  <= '0;
      bus.mem_enable <= 1'b0;
      bus.mem_rw     <= 1'b0;
      bus.mem_size   <= 2'b00;
      bus.mem_se     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            bus.rsp_rdata <= '0;
            if (req_ok) begin
              // The mem_* registers double as the latched request for the rest of the access.
              bus.mem_addr  <= bus.req_addr[MEM_ADDR_W-1:0];
              bus.mem_rw    <= bus.req_rw;
              bus.mem_size  <= bus.req_size;
              bus.mem_se    <= bus.req_sign & ~bus.req_rw;
              bus.mem_wdata <= bus.req_wdata;
              state         <= SETUP;
            end else begin
              bus.rsp_err   <= 1'b1;
              bus.rsp_valid <= 1'b1;
              state         <= RESP;
            end
          end
        end
        SETUP: begin
          bus.mem_enable <= 1'b1;
          state          <= STROBE;
        end
        STROBE: begin
          bus.mem_enable <= 1'b0;
          state          <= CAPTURE;
        end
        CAPTURE: begin
          bus.rsp_rdata <= bus.mem_rw ? '0 : bus.mem_rdata;
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          bus.mem_enable <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule
